// File: rtl/key_schedule_inv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_schedule_inv                                             |
// | Description : Iterative AES-128 decryption key scheduler (round 10 -> 0).  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module key_schedule_inv #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         keyIsLast,
  input  logic [0:127] keyIn,
  output logic [0:127] keyOut,
  output logic [0:3]   keyRound,
  output logic         keyValid,
  input  logic         keyReady,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FWD    = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] c_LAST_ROUND = 4'(NR);

  // Entry i of the S-box occupies bits [8*i : 8*i+7].
  localparam logic [0:2047] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [0:31] rotWord(input logic [0:31] w);
    return {w[8:31], w[0:7]};
  endfunction

  function automatic logic [0:31] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 32'h01000000;
      4'd2:    rcon = 32'h02000000;
      4'd3:    rcon = 32'h04000000;
      4'd4:    rcon = 32'h08000000;
      4'd5:    rcon = 32'h10000000;
      4'd6:    rcon = 32'h20000000;
      4'd7:    rcon = 32'h40000000;
      4'd8:    rcon = 32'h80000000;
      4'd9:    rcon = 32'h1b000000;
      4'd10:   rcon = 32'h36000000;
      default: rcon = 32'h00000000;
    endcase
  endfunction

  state_t       r_state;
  state_t       w_nextState;
  logic [0:127] r_key;
  logic [3:0]   r_round;
  logic [3:0]   r_cnt;

  logic [0:31]  w_w0, w_w1, w_w2, w_w3;
  logic [0:31]  w_n0, w_n1, w_n2, w_n3;
  logic [0:31]  w_p0, w_p1, w_p2, w_p3;
  logic [0:31]  w_subIn, w_subOut;

  assign w_w0 = r_key[0:31];
  assign w_w1 = r_key[32:63];
  assign w_w2 = r_key[64:95];
  assign w_w3 = r_key[96:127];

  assign w_p3 = w_w3 ^ w_w2;
  assign w_p2 = w_w2 ^ w_w1;
  assign w_p1 = w_w1 ^ w_w0;

  // One shared S-box bank: forward walk feeds w3, inverse walk feeds p3.
  assign w_subIn = (r_state == S_FWD) ? rotWord(w_w3) : rotWord(w_p3);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    logic [7:0] w_idx;
    assign w_idx = w_subIn[8*gi +: 8];
    assign w_subOut[8*gi +: 8] = c_SBOX[{w_idx, 3'b000} +: 8];
  end

  assign w_n0 = w_w0 ^ w_subOut ^ rcon(r_cnt);
  assign w_n1 = w_n0 ^ w_w1;
  assign w_n2 = w_n1 ^ w_w2;
  assign w_n3 = w_n2 ^ w_w3;
  assign w_p0 = w_w0 ^ w_subOut ^ rcon(r_round);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (start) w_nextState = keyIsLast ? S_STREAM : S_FWD;
      S_FWD:    if (r_cnt == c_LAST_ROUND) w_nextState = S_STREAM;
      S_STREAM: if (keyReady && (r_round == 4'd0)) w_nextState = S_DONE;
      S_DONE:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key   <= '0;
      r_round <= 4'd0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key   <= keyIn;
            r_round <= keyIsLast ? c_LAST_ROUND : 4'd0;
            r_cnt   <= keyIsLast ? 4'd0 : 4'd1;
          end
        end
        S_FWD: begin
          r_key <= {w_n0, w_n1, w_n2, w_n3};
          if (r_cnt == c_LAST_ROUND) begin
            r_round <= c_LAST_ROUND;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        S_STREAM: begin
          if (keyReady && (r_round != 4'd0)) begin
            r_key   <= {w_p0, w_p1, w_p2, w_p3};
            r_round <= r_round - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign keyOut   = r_key;
  assign keyRound = r_round;
  assign keyValid = (r_state == S_STREAM);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule
`default_nettype wire
